// File: rtl/vram_arbiter.sv
// vram_arbiter: time-division arbiter sharing one single-port video RAM between scan-out and a pixel writer.
// Define VRAM_WFIFO_EN to buffer writer traffic in a FIFO_DEPTH-entry FIFO; otherwise writes pass through in writer slots.
module vram_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        pix_ce,
    input  logic                        disp_active,
    input  logic [AW-1:0]               disp_addr,
    output logic [DW-1:0]               disp_q,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DW-1:0]               wr_data,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    output logic                        mem_we,
    input  logic [DW-1:0]               mem_q,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          phase_r;
    logic          rd_pend_r;
    logic [DW-1:0] disp_q_r;
    logic          writer_slot_s;
    logic          wr_go_s;
    logic [AW-1:0] wr_go_addr_s;
    logic [DW-1:0] wr_go_data_s;

    // Even cycles without an active display read are handed to the writer as well
    assign writer_slot_s = phase_r | ~disp_active;
    assign pix_ce        = phase_r;
    assign disp_q        = disp_q_r;

    // Phase toggle, pending display read and the registered display pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r   <= 1'b0;
            rd_pend_r <= 1'b0;
            disp_q_r  <= {DW{1'b0}};
        end else if (phase_r) begin
            phase_r   <= 1'b0;
            disp_q_r  <= rd_pend_r ? mem_q : {DW{1'b0}};
            rd_pend_r <= 1'b0;
        end else begin
            phase_r   <= 1'b1;
            rd_pend_r <= disp_active;
        end
    end

`ifdef VRAM_WFIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [AW-1:0] addr_buf_r [FIFO_DEPTH];
    logic [DW-1:0] data_buf_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [LW-1:0] level_r;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;

    assign empty_s      = (level_r == {LW{1'b0}});
    assign full_s       = (level_r == LVL_FULL);
    assign push_s       = wr_valid & ~full_s;
    assign pop_s        = writer_slot_s & ~empty_s;
    assign wr_ready     = ~full_s;
    assign fifo_level   = level_r;
    assign wr_go_s      = pop_s;
    assign wr_go_addr_s = addr_buf_r[rd_ptr_r];
    assign wr_go_data_s = data_buf_r[rd_ptr_r];

    // FIFO entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_buf_r[i] <= {AW{1'b0}};
                data_buf_r[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            addr_buf_r[wr_ptr_r] <= wr_addr;
            data_buf_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end
`else
    // Without buffering the writer is only accepted while it can own the RAM port
    assign wr_ready     = writer_slot_s & ~rst;
    assign wr_go_s      = wr_valid & wr_ready;
    assign wr_go_addr_s = wr_addr;
    assign wr_go_data_s = wr_data;
    assign fifo_level   = {LW{1'b0}};
`endif

    // RAM port mux: writer entry when a write is issued, otherwise the display address
    always_comb begin
        mem_addr  = disp_addr;
        mem_wdata = {DW{1'b0}};
        mem_we    = 1'b0;
        if (wr_go_s) begin
            mem_addr  = wr_go_addr_s;
            mem_wdata = wr_go_data_s;
            mem_we    = 1'b1;
        end else begin
            mem_addr  = disp_addr;
            mem_wdata = {DW{1'b0}};
            mem_we    = 1'b0;
        end
    end

endmodule
